// File: rtl/instr_loader.sv
// Boot-time program loader: packs a byte stream into 16-bit words, fills the
// remaining entries of the instruction store, then releases the core via cpu_run.
module instr_loader #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 4,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] FILL_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_run,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  // state     | meaning
  // S_IDLE    | after reset, waiting for load_start
  // S_LOAD_HI | waiting for the high byte of the next word
  // S_LOAD_LO | waiting for the low byte; writes the packed word
  // S_FILL    | writing FILL_WORD to the entries the stream did not cover
  // S_RUN     | store complete, core released
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_HI, S_LOAD_LO, S_FILL, S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [7:0]        hi_byte;
  logic [DATA_W-1:0] mem [DEPTH];

  // Asynchronous read: a same-cycle write is only visible after the edge.
  assign instr = mem[read_addr];

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      hi_byte      <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_run      <= 1'b0;
      load_done    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= FILL_WORD;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            state        <= S_LOAD_HI;
            wr_ptr       <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b1;
            cpu_run      <= 1'b0;
          end
        end
        S_LOAD_HI: begin
          if (in_valid && in_ready) begin
            hi_byte <= in_data;
            state   <= S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          if (in_valid && in_ready) begin
            mem[wr_ptr]  <= {hi_byte, in_data};
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            wr_ptr       <= wr_ptr + ADDR_W'(1);
            // A full store ends the load regardless of in_last.
            if (wr_ptr == LAST_ADDR) begin
              state     <= S_RUN;
              in_ready  <= 1'b0;
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
            end else if (in_last) begin
              state    <= S_FILL;
              in_ready <= 1'b0;
            end else begin
              state <= S_LOAD_HI;
            end
          end
        end
        S_FILL: begin
          mem[wr_ptr] <= FILL_WORD;
          wr_ptr      <= wr_ptr + ADDR_W'(1);
          if (wr_ptr == LAST_ADDR) begin
            state     <= S_RUN;
            cpu_run   <= 1'b1;
            load_done <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

endmodule
